// File: rtl/dpbe_ram_reader.sv
// Read initiator for one port of the dual-port byte-enable RAM: turns an
// (address, length) command into sequential reads and a valid/ready word stream.
module dpbe_ram_reader #(
  parameter  int W  = 256,
  parameter  int D  = 64,
  parameter  int FD = 4,
  localparam int AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [AW:0]     cmd_len,
  output logic            busy,
  output logic            done,
  output logic            ram_en,
  output logic [AW-1:0]   ram_addr,
  output logic [W/8-1:0]  ram_we,
  output logic [W-1:0]    ram_din,
  input  logic [W-1:0]    ram_dout,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_data,
  output logic            m_last
);

  localparam int LW = AW + 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int NW = PW + 1;
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_e;

  state_e state_q, state_d;

  logic          ram_en_q;
  logic [AW-1:0] ram_addr_q;
  logic [AW-1:0] next_addr_q;
  logic [LW-1:0] reads_left_q;
  logic [LW-1:0] beats_left_q;
  logic          rd_pend_q;

  logic [W-1:0]  buf_mem [FD];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [NW-1:0] count_q;

  logic          cmd_fire;
  logic          pop;
  logic [CW-1:0] occ;
  logic          credit_ok;
  logic          issue_run;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(D - 1)) ? '0 : a + AW'(1);
  endfunction

  assign cmd_fire = cmd_valid && (state_q == ST_IDLE);
  assign pop      = m_valid && m_ready;

  // Occupancy if one more read is issued now: buffered words, the read on the
  // RAM port this cycle, the word landing this cycle, minus this cycle's pop.
  assign occ       = CW'(count_q) + CW'(ram_en_q) + CW'(rd_pend_q) - CW'(pop);
  assign credit_ok = occ < CW'(FD);
  assign issue_run = (state_q == ST_RUN) && (reads_left_q != '0) && credit_ok;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_fire) begin
          state_d = (cmd_len == '0) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (pop && m_last) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read issue and beat accounting. rd_pend_q marks the cycle in which the
  // RAM's registered output holds the word requested one cycle earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_q     <= 1'b0;
      ram_addr_q   <= '0;
      next_addr_q  <= '0;
      reads_left_q <= '0;
      beats_left_q <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      rd_pend_q <= ram_en_q;
      ram_en_q  <= 1'b0;
      if (cmd_fire) begin
        beats_left_q <= cmd_len;
        if (cmd_len != '0) begin
          ram_en_q     <= 1'b1;
          ram_addr_q   <= cmd_addr;
          next_addr_q  <= addr_inc(cmd_addr);
          reads_left_q <= cmd_len - LW'(1);
        end else begin
          reads_left_q <= '0;
        end
      end else begin
        if (issue_run) begin
          ram_en_q     <= 1'b1;
          ram_addr_q   <= next_addr_q;
          next_addr_q  <= addr_inc(next_addr_q);
          reads_left_q <= reads_left_q - LW'(1);
        end
        if (pop) begin
          beats_left_q <= beats_left_q - LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (rd_pend_q) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + NW'(rd_pend_q) - NW'(pop);
    end
  end

  // NOTE: the word storage is deliberately not reset; the pointers and count
  // alone decide which entries are live, and m_data is forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (rd_pend_q) begin
      buf_mem[wr_ptr_q] <= ram_dout;
    end
  end

  assign m_valid  = (count_q != '0);
  assign m_data   = m_valid ? buf_mem[rd_ptr_q] : '0;
  assign m_last   = m_valid && (beats_left_q == LW'(1));

  assign ram_en   = ram_en_q;
  assign ram_addr = ram_addr_q;
  assign ram_we   = '0;
  assign ram_din  = '0;

endmodule

// File: tb/tb_dpbe_ram_reader.sv
// Self-checking bench for dpbe_ram_reader: a behavioural RAM plus a word-order
// reference computed directly from (addr + k) mod D.
module tb_dpbe_ram_reader;

  localparam int W  = 256;
  localparam int D  = 64;
  localparam int FD = 4;
  localparam int AW = 6;
  localparam int LW = AW + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [AW-1:0]  cmd_addr;
  logic [AW:0]    cmd_len;
  logic           busy;
  logic           done;
  logic           ram_en;
  logic [AW-1:0]  ram_addr;
  logic [W/8-1:0] ram_we;
  logic [W-1:0]   ram_din;
  logic [W-1:0]   ram_dout;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic           m_last;

  logic [W-1:0]   mem [D];

  int vectors     = 0;
  int miscompares = 0;

  dpbe_ram_reader #(.W(W), .D(D), .FD(FD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep_word(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {(W/8){b}};
  endfunction

  // mode 0: m_ready always 1 (exact timing checked); 1: random 50%;
  // 2: m_ready low for relative cycles 2..20.
  task automatic run_cmd(input int addr, input int len, input int mode,
                         input int abort_beats, input bit noise);
    int reads = 0;
    int beats = 0;
    int last_rel = -1;
    bit prev_stall = 1'b0;
    bit finished = 1'b0;
    bit done_seen = 1'b0;
    bit done_exp;
    logic [W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    for (int rel = 0; rel < 2000; rel++) begin
      if (rel > 0) begin
        @(negedge clk);
        cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_addr  = AW'($urandom_range(0, D - 1));
        cmd_len   = LW'($urandom_range(0, 2 * D - 1));
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = !(rel >= 2 && rel <= 20);
      endcase
      #1;
      if (rel == 0) check("cmd_ready_idle", cmd_ready, 1);
      else          check("cmd_ready_low", cmd_ready, 0);
      check("busy", busy, (len != 0) && (rel >= 1) && !finished);
      check("ram_we_din", {ram_we, ram_din}, '0);
      if (ram_en) begin
        check("read_count", reads < len, 1);
        check("ram_addr", ram_addr, (addr + reads) % D);
        check("credit", (reads + 1 - beats) <= FD, 1);
        if (mode == 0) check("read_time", rel, 1 + reads);
        reads++;
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        check("beat_count", beats < len, 1);
        check("m_data", m_data, mem[(addr + beats) % D]);
        check("m_last", m_last, beats == len - 1);
        if (mode == 0) check("beat_time", rel, 3 + beats);
        beats++;
        if (beats == len) begin
          finished = 1'b1;
          last_rel = rel;
        end
      end
      done_exp = (len == 0) ? (rel == 1) : (last_rel >= 0 && rel == last_rel + 1);
      check("done", done, done_exp);
      if (mode == 2 && rel == 20) check("stall_reads", reads, 4);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      if (abort_beats > 0 && beats == abort_beats) return;
    end
    check("timeout", done_seen, 1);
    check("reads_total", reads, len);
    check("beats_total", beats, len);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("cmd_ready_back", cmd_ready, 1);
    check("done_once", done, 0);
    check("idle_valid", m_valid, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    m_ready   = 1'b0;
    for (int i = 0; i < D; i++) mem[i] = rep_word(i);
    #1;
    check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_cmd(5, 4, 0, 0, 1'b0);
    run_cmd(62, 4, 0, 0, 1'b0);
    run_cmd(0, 0, 0, 0, 1'b0);
    run_cmd(0, 16, 1, 0, 1'b0);
    run_cmd(0, 10, 2, 0, 1'b0);

    // reset mid-command after three beats of an 8-word read
    run_cmd(0, 8, 0, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_valid", m_valid, 0);
      check("post_rst_done", done, 0);
      check("post_rst_ram_en", ram_en, 0);
    end
    run_cmd(0, 2, 0, 0, 1'b0);

    // random contents, commands, backpressure and ignored command noise
    for (int i = 0; i < D; i++)
      for (int j = 0; j < W / 32; j++) mem[i][j*32 +: 32] = $urandom;
    for (int n = 0; n < 8; n++) begin
      run_cmd($urandom_range(0, D - 1), $urandom_range(0, 2 * D - 1),
              $urandom_range(0, 1), 0, 1'b1);
    end
    run_cmd(D - 1, 2 * D - 1, 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dpbe_ram_reader.md
Name: dpbe_ram_reader

Overview:
- Read initiator for one port of the dual-port byte-enable RAM.
- Accepts a (start address, length) command and issues sequential single-cycle RAM reads.
- Absorbs the RAM's 1-cycle registered read latency.
- Delivers words as a valid/ready stream with last-beat marking; sustains one word per clock under backpressure.

Parameters:
- W, 256, data width in bits (multiple of 8); matches RAM W.
- D, 64, RAM depth in words; AW = clogb2(D) address bits.
- FD, 4, output buffer depth in words (fixed 4; power of two).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both valid and ready are high.
- cmd_addr  in  AW  first word address.
- cmd_len  in  AW+1  number of words to read, 0..2D-1.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse after the final beat handshakes.
- ram_en  out  1  RAM port enable.
- ram_addr  out  AW  RAM port address.
- ram_we  out  W/8  byte write enables; constant 0.
- ram_din  out  W  write data; constant 0.
- ram_dout  in  W  RAM read data; valid in the cycle after ram_en is high.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream sink ready.
- m_data  out  W  stream word.
- m_last  out  1  marks the final word of the command.

Behaviour:
- Async reset (rst_n=0), applied immediately:
  - state=IDLE; cmd_ready=1.
  - busy=0, done=0, ram_en=0, ram_addr=0, m_valid=0, m_last=0, m_data=0.
  - Buffer, counters and in-flight tracking cleared.
- Reset mid-command: all pending and in-flight data discarded. No beats or done pulse after release.
- States:
  - IDLE: cmd_ready=1, busy=0. On cmd handshake, latch addr and len.
    - len=0: go to FINISH (no RAM reads, no beats).
    - Otherwise: go to RUN.
  - RUN: cmd_ready=0, busy=1. Issues reads and drains the buffer. When the beat with m_last handshakes, go to FINISH.
  - FINISH: done=1 for exactly this cycle, busy=0, cmd_ready=0. Next state IDLE.
- Read issue:
  - ram_en is registered.
  - First read is in the cycle after the cmd handshake.
  - ram_addr increments by 1 per issued read and wraps D-1 -> 0.
  - Lengths > D wrap and re-read addresses.
  - Exactly len reads are issued per command; ram_en is never high in IDLE or FINISH.
- Capture: ram_dout is written into the buffer in the cycle after each ram_en=1 cycle.
- Credit rule: issue a read in a cycle only if (buffer occupancy + reads issued but not yet captured − pop this cycle) < FD. The buffer never overflows.
- Latency:
  - Handshake in cycle 0 -> ram_en in cycle 1 -> capture at end of cycle 2 -> m_valid in cycle 3.
  - With m_ready held high, beats appear on consecutive cycles (no bubbles).
- Stream rules:
  - m_data, m_last and m_valid are held stable while m_valid=1 and m_ready=0.
  - Pop occurs on m_valid & m_ready.
  - m_last=1 only on beat number len.
- Simultaneous events: capture and pop in the same cycle leaves occupancy unchanged. Credit includes that cycle's pop.
- Commands presented while cmd_ready=0 are ignored and not latched.
- m_ready toggling arbitrarily must never drop, duplicate or reorder words.

Test Plan:
- Preload m[i]=i replicated bytes; cmd addr=5, len=4, m_ready=1:
  - ram_en high in cycles 1-4, addrs 5,6,7,8.
  - m_data = words 5..8 in cycles 3-6; m_last in cycle 6; done in cycle 7.
- cmd addr=62, len=4 (D=64): addrs 62,63,0,1; data order matches; m_last on word 1.
- cmd len=0: no ram_en, no m_valid; done pulses 1 cycle after the handshake; cmd_ready returns the next cycle.
- cmd addr=0, len=16 with m_ready random 50%:
  - Exactly 16 beats, in order, with no gaps in content.
  - Buffer never exceeds 4 entries.
  - Data held stable while stalled.
- cmd addr=0, len=10; m_ready=0 from cycle 2 to cycle 20, then 1:
  - ram_en stops after 4 reads.
  - The remaining 6 reads resume once the stall releases; all 10 beats delivered.
- rst_n pulsed low mid-command (after 3 beats of len=8):
  - Outputs reach reset values immediately.
  - No further beats and no done.
  - A new command addr=0, len=2 completes normally.
